// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: statemt geometry and widths, the S-box table,
// the round-stage FSM states and the ShiftRows source mapping.
package aes_pkg;

    localparam int NB     = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_READ_LAST,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte that lands at address a after ShiftRows: row a[1:0] rotated left by its row index.
    function automatic logic [3:0] shift_src(input logic [3:0] a);
        logic [1:0] row;
        logic [1:0] col;
        row = a[1:0];
        col = a[3:2] + row;
        return {col, row};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup of one byte.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    import aes_pkg::*;

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/byte_sub_shift_row.sv
// AES SubBytes + ShiftRows applied in place to the 16-byte state in the shared
// statemt dual-port memory: two bytes read per cycle into a local buffer, then written back shifted.
module byte_sub_shift_row #(
    parameter int NB     = aes_pkg::NB,
    parameter int ADDR_W = aes_pkg::ADDR_W,
    parameter int DATA_W = aes_pkg::DATA_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [ADDR_W-1:0] statemt_address0,
    output logic              statemt_ce0,
    output logic              statemt_we0,
    output logic [DATA_W-1:0] statemt_d0,
    input  logic [DATA_W-1:0] statemt_q0,
    output logic [ADDR_W-1:0] statemt_address1,
    output logic              statemt_ce1,
    output logic              statemt_we1,
    output logic [DATA_W-1:0] statemt_d1,
    input  logic [DATA_W-1:0] statemt_q1
);
    import aes_pkg::*;

    state_t     r_state;
    logic [2:0] r_k;
    logic [7:0] r_buf [NB*NB];

    logic [7:0] w_sub0;
    logic [7:0] w_sub1;
    logic       w_cap_en;
    logic [2:0] w_cap_pair;
    logic [3:0] w_pair_a0;
    logic [3:0] w_pair_a1;
    logic       w_unused_q;

    aes_sbox u_sbox0 (.i_byte(statemt_q0[7:0]), .o_byte(w_sub0));
    aes_sbox u_sbox1 (.i_byte(statemt_q1[7:0]), .o_byte(w_sub1));

    assign w_unused_q = ^{statemt_q0[DATA_W-1:8], statemt_q1[DATA_W-1:8]};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_state <= ST_READ;
                        r_k     <= '0;
                    end
                end
                ST_READ: begin
                    r_k <= r_k + 3'd1;
                    if (r_k == 3'd7) r_state <= ST_READ_LAST;
                end
                ST_READ_LAST: begin
                    r_state <= ST_WRITE;
                    r_k     <= '0;
                end
                ST_WRITE: begin
                    r_k <= r_k + 3'd1;
                    if (r_k == 3'd7) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read data trails its address by one cycle; r_k has wrapped to 0 in READ_LAST, so k-1 selects pair 7.
    assign w_cap_en   = ((r_state == ST_READ) && (r_k != 3'd0)) || (r_state == ST_READ_LAST);
    assign w_cap_pair = r_k - 3'd1;

    // NOTE: the byte buffer has no reset; it is always fully refilled before being read.
    always_ff @(posedge ap_clk) begin
        if (w_cap_en) begin
            r_buf[{w_cap_pair, 1'b0}] <= w_sub0;
            r_buf[{w_cap_pair, 1'b1}] <= w_sub1;
        end
    end

    assign w_pair_a0 = {r_k, 1'b0};
    assign w_pair_a1 = {r_k, 1'b1};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        ap_idle          = 1'b0;
        ap_done          = 1'b0;
        statemt_address0 = '0;
        statemt_address1 = '0;
        statemt_ce0      = 1'b0;
        statemt_ce1      = 1'b0;
        statemt_we0      = 1'b0;
        statemt_we1      = 1'b0;
        statemt_d0       = '0;
        statemt_d1       = '0;
        unique case (r_state)
            ST_IDLE: ap_idle = 1'b1;
            ST_READ: begin
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_address0 = ADDR_W'(w_pair_a0);
                statemt_address1 = ADDR_W'(w_pair_a1);
            end
            ST_WRITE: begin
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_we0      = 1'b1;
                statemt_we1      = 1'b1;
                statemt_address0 = ADDR_W'(w_pair_a0);
                statemt_address1 = ADDR_W'(w_pair_a1);
                statemt_d0       = DATA_W'(r_buf[shift_src(w_pair_a0)]);
                statemt_d1       = DATA_W'(r_buf[shift_src(w_pair_a1)]);
            end
            ST_DONE: ap_done = 1'b1;
            default: ;
        endcase
    end

    assign ap_ready = ap_done;

endmodule

// File: tb/tb_byte_sub_shift_row.sv
// Self-checking bench for byte_sub_shift_row: a statemt memory model, a cycle-indexed
// output model with a GF(2^8)-derived S-box, and end-of-pass state checks.
module tb_byte_sub_shift_row;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [4:0]  statemt_address0;
    logic        statemt_ce0;
    logic        statemt_we0;
    logic [31:0] statemt_d0;
    logic [31:0] statemt_q0;
    logic [4:0]  statemt_address1;
    logic        statemt_ce1;
    logic        statemt_we1;
    logic [31:0] statemt_d1;
    logic [31:0] statemt_q1;

    byte_sub_shift_row dut (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .ap_ready         (ap_ready),
        .statemt_address0 (statemt_address0),
        .statemt_ce0      (statemt_ce0),
        .statemt_we0      (statemt_we0),
        .statemt_d0       (statemt_d0),
        .statemt_q0       (statemt_q0),
        .statemt_address1 (statemt_address1),
        .statemt_ce1      (statemt_ce1),
        .statemt_we1      (statemt_we1),
        .statemt_d1       (statemt_d1),
        .statemt_q1       (statemt_q1)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int phase    = -1;

    logic [31:0] mem [32];
    logic [31:0] img [32];
    logic        load_req = 1'b0;
    logic [7:0]  sbox_ref [256];
    logic [7:0]  snap [16];
    logic [7:0]  pre [16];

    logic [7:0] fips_in  [16] = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                                  8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
    logic [7:0] fips_out [16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                                  8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] v, int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic int src_of(int a);
        int r;
        int c;
        r = a % 4;
        c = a / 4;
        return r + 4 * ((c + r) % 4);
    endfunction

    function automatic logic [127:0] pack_out(logic done, logic idle, logic ready,
                                              logic ce0, logic ce1, logic we0, logic we1,
                                              logic [4:0] a0, logic [4:0] a1,
                                              logic [31:0] d0, logic [31:0] d1);
        return {47'd0, done, idle, ready, ce0, ce1, we0, we1, a0, a1, d0, d1};
    endfunction

    function automatic logic [127:0] dut_bus();
        return pack_out(ap_done, ap_idle, ap_ready, statemt_ce0, statemt_ce1,
                        statemt_we0, statemt_we1, statemt_address0, statemt_address1,
                        statemt_d0, statemt_d1);
    endfunction

    // Outputs for cycle ph of a pass (0 = idle, 1..8 read, 9 drain, 10..17 write, 18 done).
    function automatic logic [127:0] exp_bus(int ph);
        int k;
        int a0;
        if (ph == 0)
            return pack_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        if (ph >= 1 && ph <= 8) begin
            k = ph - 1;
            return pack_out(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                            5'(2 * k), 5'(2 * k + 1), 32'd0, 32'd0);
        end
        if (ph >= 10 && ph <= 17) begin
            k  = ph - 10;
            a0 = 2 * k;
            return pack_out(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'(a0), 5'(a0 + 1),
                            {24'd0, sbox_ref[snap[src_of(a0)]]},
                            {24'd0, sbox_ref[snap[src_of(a0 + 1)]]});
        end
        if (ph == 18)
            return pack_out(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        return pack_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    endfunction

    // statemt memory: synchronous read, write when we, bulk preload from img.
    always @(posedge ap_clk) begin
        if (load_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= img[i];
        end else begin
            if (statemt_ce0) begin
                if (statemt_we0) mem[statemt_address0] <= statemt_d0;
                else             statemt_q0 <= mem[statemt_address0];
            end
            if (statemt_ce1) begin
                if (statemt_we1) mem[statemt_address1] <= statemt_d1;
                else             statemt_q1 <= mem[statemt_address1];
            end
        end
    end

    // Pass tracker: which cycle of a pass the block is in, plus the state image at acceptance.
    always @(posedge ap_clk) begin
        if (ap_rst === 1'b1) begin
            phase <= 0;
        end else if (phase == 0) begin
            if (ap_start === 1'b1) begin
                phase <= 1;
                for (int i = 0; i < 16; i++) snap[i] <= mem[i][7:0];
            end
        end else if (phase == 18) begin
            phase <= 0;
        end else if (phase > 0) begin
            phase <= phase + 1;
        end
    end

    always @(negedge ap_clk) begin
        if (ap_done === 1'b1) n_done <= n_done + 1;
        if (phase >= 0) check($sformatf("outputs_phase%0d", phase), dut_bus(), exp_bus(phase));
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_load();
        for (int i = 0; i < 16; i++) pre[i] = img[i][7:0];
        for (int i = 16; i < 32; i++) img[i] = 32'ha5a5a5a5;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic run_pass(output int lat);
        lat = -1;
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            if (ap_done === 1'b1) lat = c;
            step();
        end
    endtask

    task automatic check_state(input string tag);
        int bad_hi;
        for (int a = 0; a < 16; a++)
            check($sformatf("%s_word%0d", tag, a), mem[a], {24'd0, sbox_ref[pre[src_of(a)]]});
        bad_hi = 0;
        for (int a = 16; a < 32; a++) if (mem[a] !== 32'ha5a5a5a5) bad_hi++;
        check($sformatf("%s_upper_untouched", tag), bad_hi, 0);
    endtask

    initial begin
        logic [7:0] inv;
        int lat;
        int cnt;
        int first_done;
        int second_done;
        int done_before;
        int bad;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        check("model_sbox_00", sbox_ref[0], 8'h63);
        check("model_sbox_53", sbox_ref[8'h53], 8'hed);
        check("model_sbox_63", sbox_ref[8'h63], 8'hfb);

        ap_rst   = 1'b1;
        ap_start = 1'b0;
        for (int i = 0; i < 32; i++) img[i] = 32'd0;
        repeat (3) step();
        check("reset_outputs", dut_bus(),
              pack_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0));
        ap_rst = 1'b0;
        step();

        // FIPS-197 round 1
        for (int i = 0; i < 16; i++) img[i] = {24'd0, fips_in[i]};
        do_load();
        run_pass(lat);
        check("fips_latency", lat, 18);
        for (int i = 0; i < 16; i++) check($sformatf("fips_word%0d", i), mem[i], {24'd0, fips_out[i]});

        // all-zero state
        for (int i = 0; i < 16; i++) img[i] = 32'd0;
        do_load();
        run_pass(lat);
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== 32'h00000063) bad++;
        check("zero_state_words", bad, 0);

        // upper bits of q ignored; addresses 16..31 untouched
        img[0] = 32'hffffff00;
        do_load();
        run_pass(lat);
        check("upper_bits_latency", lat, 18);
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== 32'h00000063) bad++;
        check("upper_bits_words", bad, 0);
        check_state("upper_bits");

        // reset in cycle 12 of a pass
        for (int i = 0; i < 16; i++) img[i] = {24'd0, fips_in[i]};
        do_load();
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        repeat (11) step();
        done_before = n_done;
        ap_rst = 1'b1;
        step();
        check("abort_outputs", dut_bus(),
              pack_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0));
        ap_rst = 1'b0;
        repeat (25) step();
        check("abort_no_done", n_done - done_before, 0);
        for (int i = 0; i < 4; i++) check($sformatf("abort_written%0d", i), mem[i], {24'd0, fips_out[i]});
        for (int i = 6; i < 16; i++) check($sformatf("abort_kept%0d", i), mem[i], {24'd0, fips_in[i]});

        // start held high across two back-to-back passes
        for (int i = 0; i < 16; i++) img[i] = 32'd0;
        do_load();
        cnt = 0;
        first_done = -1;
        second_done = -1;
        ap_start = 1'b1;
        step();
        for (int c = 1; c <= 45; c++) begin
            if (c == 20) ap_start = 1'b0;
            if (ap_done === 1'b1) begin
                cnt++;
                if (first_done < 0) first_done = c;
                else                second_done = c;
            end
            step();
        end
        check("held_done_count", cnt, 2);
        check("held_first_done", first_done, 18);
        check("held_second_done", second_done, 37);
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== 32'h000000fb) bad++;
        check("held_twice_words", bad, 0);

        // start pulses during READ and WRITE are ignored
        for (int i = 0; i < 16; i++) img[i] = $urandom;
        do_load();
        cnt = 0;
        first_done = -1;
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            ap_start = (c == 4 || c == 13);
            if (ap_done === 1'b1) begin
                cnt++;
                if (first_done < 0) first_done = c;
            end
            step();
        end
        ap_start = 1'b0;
        check("pulse_done_count", cnt, 1);
        check("pulse_done_cycle", first_done, 18);
        check_state("pulse");

        // randomized states with random idle gaps
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 16; i++) img[i] = $urandom;
            do_load();
            repeat ($urandom_range(0, 3)) step();
            run_pass(lat);
            check($sformatf("rand%0d_latency", t), lat, 18);
            check_state($sformatf("rand%0d", t));
        end

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
